// File: rtl/conv_pkg.sv
// Shared types and pooled-geometry helpers for the CONV layer sequencer
// and the window read-address generator.
package conv_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BIAS,
        S_RUN,
        S_DRAIN,
        S_NEXT,
        S_DONE
    } state_t;

    localparam int TAPS  = 9;
    localparam int QUADS = 4;

    function automatic int pool_w(input int w);
        return (w - 2) / 2;
    endfunction

    function automatic int pool_h(input int h);
        return (h - 2) / 2;
    endfunction

    function automatic int pool_n(input int w, input int h);
        return pool_w(w) * pool_h(h);
    endfunction

endpackage

// File: rtl/conv_layer_sequencer_if.sv
// Control/status bundle between the layer controller (master) and
// the CONV layer sequencer (slave).
interface conv_layer_sequencer_if #(
    parameter int AW  = 9,
    parameter int WAW = 10
);
    logic           iSTART;
    logic           iHOLD;
    logic           oBUSY;
    logic           oDONE;
    logic           oBIAS_LD;
    logic [3:0]     oOC;
    logic           oTAP_VALID;
    logic [3:0]     oPOS_I;
    logic [4:0]     oPOS_J;
    logic [1:0]     oQUAD;
    logic [3:0]     oIN_CH;
    logic [3:0]     oTAP;
    logic [WAW-1:0] oWT_ADDR;
    logic           oACC_CLR;
    logic           oACC_LAST;
    logic           oCONV_VALID;
    logic           oPOOL_VALID;
    logic [AW-1:0]  oWR_ADDR;

    modport master (
        output iSTART, iHOLD,
        input  oBUSY, oDONE, oBIAS_LD, oOC, oTAP_VALID,
        input  oPOS_I, oPOS_J, oQUAD, oIN_CH, oTAP, oWT_ADDR,
        input  oACC_CLR, oACC_LAST, oCONV_VALID, oPOOL_VALID,
        input  oWR_ADDR
    );

    modport slave (
        input  iSTART, iHOLD,
        output oBUSY, oDONE, oBIAS_LD, oOC, oTAP_VALID,
        output oPOS_I, oPOS_J, oQUAD, oIN_CH, oTAP, oWT_ADDR,
        output oACC_CLR, oACC_LAST, oCONV_VALID, oPOOL_VALID,
        output oWR_ADDR
    );
endinterface

// File: rtl/conv_valid_pipe.sv
// Fixed-depth shift register matching the MAC pipeline latency;
// it carries {conv-valid, pool-valid, write address}.
module conv_valid_pipe #(
    parameter int DEPTH = 3,
    parameter int W     = 11
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_sr [DEPTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < DEPTH; k++) r_sr[k] <= '0;
        end else begin
            r_sr[0] <= i_d;
            for (int k = 1; k < DEPTH; k++) r_sr[k] <= r_sr[k-1];
        end
    end

    assign o_q = r_sr[DEPTH-1];
endmodule

// File: rtl/conv_layer_sequencer.sv
// Schedules one CONV layer over a shared 3x3 MAC: one tap per cycle,
// nested tap < in_ch < quad < pos_i < pos_j, repeated per output channel.
module conv_layer_sequencer
    import conv_pkg::*;
#(
    parameter int WIDTH    = 14,
    parameter int HEIGHT   = 18,
    parameter int IN_CH    = 4,
    parameter int OUT_CH   = 8,
    parameter int PIPE_LAT = 3,
    parameter int AW       = 9,
    parameter int WAW      = 10
) (
    input  logic iCLK,
    input  logic iRST,
    conv_layer_sequencer_if.slave bus
);
    localparam int PW = pool_w(WIDTH);
    localparam int PH = pool_h(HEIGHT);
    localparam int P  = pool_n(WIDTH, HEIGHT);

    if (OUT_CH * P > (1 << AW)) begin : g_bad_aw
        $error("conv_layer_sequencer: OUT_CH*P exceeds AW range");
    end
    if (OUT_CH * IN_CH * TAPS > (1 << WAW)) begin : g_bad_waw
        $error("conv_layer_sequencer: weight space exceeds WAW range");
    end

    state_t         r_state;
    logic           r_busy, r_done, r_bias, r_tv, r_clr, r_last;
    logic [3:0]     r_oc, r_pi, r_ic, r_tap;
    logic [4:0]     r_pj;
    logic [1:0]     r_q;
    logic [2:0]     r_dcnt;
    logic [WAW-1:0] r_wt;
    logic [AW-1:0]  r_wr;

    logic           w_tap_end, w_ic_end, w_q_end, w_pi_end, w_final;
    logic [3:0]     w_tap_n, w_ic_n, w_pi_n;
    logic [4:0]     w_pj_n;
    logic [1:0]     w_q_n;
    logic [WAW-1:0] w_wt_n;
    logic [AW-1:0]  w_wr_n;
    logic           w_clr_n, w_last_n;
    logic [AW+1:0]  w_pipe_d, w_pipe_q;

    // Ripple-carry style counter advance for the tap after the current one.
    always_comb begin
        w_tap_end = (r_tap == 4'(TAPS - 1));
        w_ic_end  = w_tap_end && (r_ic == 4'(IN_CH - 1));
        w_q_end   = w_ic_end && (r_q == 2'(QUADS - 1));
        w_pi_end  = w_q_end && (r_pi == 4'(PW - 1));
        w_final   = w_pi_end && (r_pj == 5'(PH - 1));
        w_tap_n   = w_tap_end ? 4'd0 : r_tap + 4'd1;
        w_ic_n    = !w_tap_end ? r_ic : (w_ic_end ? 4'd0 : r_ic + 4'd1);
        w_q_n     = !w_ic_end ? r_q : (w_q_end ? 2'd0 : r_q + 2'd1);
        w_pi_n    = !w_q_end ? r_pi : (w_pi_end ? 4'd0 : r_pi + 4'd1);
        w_pj_n    = !w_pi_end ? r_pj : (w_final ? 5'd0 : r_pj + 5'd1);
        w_wt_n    = WAW'((32'(r_oc) * 32'(IN_CH) + 32'(w_ic_n))
                    * 32'(TAPS) + 32'(w_tap_n));
        w_wr_n    = AW'(32'(r_oc) * 32'(P) + 32'(w_pj_n) * 32'(PW)
                    + 32'(w_pi_n));
        w_clr_n   = (w_ic_n == 4'd0) && (w_tap_n == 4'd0);
        w_last_n  = (w_ic_n == 4'(IN_CH - 1)) && (w_tap_n == 4'(TAPS - 1));
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_bias  <= 1'b0;
            r_tv    <= 1'b0;
            r_clr   <= 1'b0;
            r_last  <= 1'b0;
            r_oc    <= '0;
            r_pi    <= '0;
            r_pj    <= '0;
            r_q     <= '0;
            r_ic    <= '0;
            r_tap   <= '0;
            r_dcnt  <= '0;
            r_wt    <= '0;
            r_wr    <= '0;
        end else begin
            r_bias <= 1'b0;
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.iSTART) begin
                        r_state <= S_BIAS;
                        r_busy  <= 1'b1;
                        r_bias  <= 1'b1;
                    end
                end
                S_BIAS: begin
                    r_state <= S_RUN;
                    r_tv    <= 1'b1;
                    r_clr   <= 1'b1;
                    r_last  <= 1'b0;
                    r_wt    <= WAW'(32'(r_oc) * 32'(IN_CH * TAPS));
                    r_wr    <= AW'(32'(r_oc) * 32'(P));
                end
                S_RUN: begin
                    if (bus.iHOLD) begin
                        r_tv <= 1'b0;
                    end else if (w_final) begin
                        r_state <= S_DRAIN;
                        r_tv    <= 1'b0;
                        r_clr   <= 1'b0;
                        r_last  <= 1'b0;
                        r_dcnt  <= '0;
                    end else begin
                        r_tv   <= 1'b1;
                        r_tap  <= w_tap_n;
                        r_ic   <= w_ic_n;
                        r_q    <= w_q_n;
                        r_pi   <= w_pi_n;
                        r_pj   <= w_pj_n;
                        r_wt   <= w_wt_n;
                        r_wr   <= w_wr_n;
                        r_clr  <= w_clr_n;
                        r_last <= w_last_n;
                    end
                end
                S_DRAIN: begin
                    if (r_dcnt == 3'(PIPE_LAT - 1)) r_state <= S_NEXT;
                    else r_dcnt <= r_dcnt + 3'd1;
                end
                S_NEXT: begin
                    r_tap <= '0;
                    r_ic  <= '0;
                    r_q   <= '0;
                    r_pi  <= '0;
                    r_pj  <= '0;
                    if (r_oc == 4'(OUT_CH - 1)) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_oc    <= r_oc + 4'd1;
                        r_state <= S_BIAS;
                        r_bias  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_oc    <= '0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // The MAC pipe cannot stall, so only genuinely issued last taps enter.
    assign w_pipe_d = {r_last & r_tv, r_last & r_tv & (r_q == 2'd3), r_wr};

    conv_valid_pipe #(
        .DEPTH(PIPE_LAT),
        .W    (AW + 2)
    ) u_pipe (
        .i_clk(iCLK),
        .i_rst(iRST),
        .i_d  (w_pipe_d),
        .o_q  (w_pipe_q)
    );

    assign bus.oBUSY       = r_busy;
    assign bus.oDONE       = r_done;
    assign bus.oBIAS_LD    = r_bias;
    assign bus.oOC         = r_oc;
    assign bus.oTAP_VALID  = r_tv;
    assign bus.oPOS_I      = r_pi;
    assign bus.oPOS_J      = r_pj;
    assign bus.oQUAD       = r_q;
    assign bus.oIN_CH      = r_ic;
    assign bus.oTAP        = r_tap;
    assign bus.oWT_ADDR    = r_wt;
    assign bus.oACC_CLR    = r_clr;
    assign bus.oACC_LAST   = r_last;
    assign bus.oCONV_VALID = w_pipe_q[AW+1];
    assign bus.oPOOL_VALID = w_pipe_q[AW];
    assign bus.oWR_ADDR    = w_pipe_q[AW-1:0];
endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Random holds and stray starts, checked each cycle against an expected
// per-layer trace built from the scheduling rules.
`timescale 1ns/1ps
module tb_conv_layer_sequencer;
    localparam int WIDTH    = 14;
    localparam int HEIGHT   = 18;
    localparam int IN_CH    = 2;
    localparam int OUT_CH   = 2;
    localparam int PIPE_LAT = 3;
    localparam int AW       = 9;
    localparam int WAW      = 10;
    localparam int PW       = (WIDTH - 2) / 2;
    localparam int PH       = (HEIGHT - 2) / 2;
    localparam int P        = PW * PH;

    logic iCLK = 1'b0;
    logic iRST = 1'b1;
    always #5 iCLK = ~iCLK;

    conv_layer_sequencer_if #(.AW(AW), .WAW(WAW)) bus ();

    conv_layer_sequencer #(
        .WIDTH   (WIDTH),
        .HEIGHT  (HEIGHT),
        .IN_CH   (IN_CH),
        .OUT_CH  (OUT_CH),
        .PIPE_LAT(PIPE_LAT),
        .AW      (AW),
        .WAW     (WAW)
    ) dut (
        .iCLK(iCLK),
        .iRST(iRST),
        .bus (bus)
    );

    typedef struct {
        bit busy, bias, done, tv, clr, last, hin, sin;
        int oc, pj, pi, q, ic, t;
    } ent_t;

    ent_t tr[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk(tag, {bus.oBUSY, bus.oDONE, bus.oBIAS_LD, bus.oTAP_VALID,
                  bus.oCONV_VALID, bus.oPOOL_VALID}, 0);
    endtask

    // Expected cycle-by-cycle trace of one layer, holds inserted in place.
    task automatic build(input bit rnd);
        ent_t e;
        int L;
        tr.delete();
        for (int oc = 0; oc < OUT_CH; oc++) begin
            e = '{default: 0};
            e.busy = 1; e.bias = 1; e.oc = oc;
            e.hin = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            e.sin = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            tr.push_back(e);
            for (int pj = 0; pj < PH; pj++)
            for (int pi = 0; pi < PW; pi++)
            for (int q = 0; q < 4; q++)
            for (int ic = 0; ic < IN_CH; ic++)
            for (int t = 0; t < 9; t++) begin
                e = '{default: 0};
                e.busy = 1; e.tv = 1;
                e.oc = oc; e.pj = pj; e.pi = pi; e.q = q; e.ic = ic; e.t = t;
                e.clr  = (ic == 0) && (t == 0);
                e.last = (ic == IN_CH - 1) && (t == 8);
                e.sin  = rnd && ($urandom_range(0, 99) == 0);
                L = 0;
                if (oc == 0 && pj == 0 && pi == 0 && q == 1 && ic == 0 && t == 4)
                    L = 5;
                else if (rnd && $urandom_range(0, 399) == 0)
                    L = int'($urandom_range(1, 6));
                e.hin = (L > 0);
                tr.push_back(e);
                for (int h = 1; h <= L; h++) begin
                    e.tv  = 0;
                    e.hin = (h < L);
                    e.sin = rnd && ($urandom_range(0, 3) == 0);
                    tr.push_back(e);
                end
            end
            for (int d = 0; d <= PIPE_LAT; d++) begin
                e = '{default: 0};
                e.busy = 1; e.oc = oc;
                e.hin = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                e.sin = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                tr.push_back(e);
            end
        end
        e = '{default: 0};
        e.busy = 1; e.done = 1;
        e.hin = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        tr.push_back(e);
    endtask

    task automatic run_layer(input int stop_at);
        ent_t e, p;
        int n, dones;
        bit ec, ep;
        int ew;
        n = (stop_at < 0) ? tr.size() : stop_at;
        dones = 0;
        @(negedge iCLK);
        chk_idle("idle_pre");
        bus.iSTART = 1'b1;
        bus.iHOLD  = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge iCLK);
            e = tr[i];
            chk($sformatf("strobes@%0d", i),
                {bus.oBUSY, bus.oBIAS_LD, bus.oDONE, bus.oTAP_VALID},
                {e.busy, e.bias, e.done, e.tv});
            if (bus.oDONE === 1'b1) dones++;
            if (e.bias) chk($sformatf("bias_oc@%0d", i), bus.oOC, e.oc);
            if (e.tv) begin
                chk($sformatf("tap_idx@%0d", i),
                    {bus.oOC, bus.oPOS_J, bus.oPOS_I, bus.oQUAD,
                     bus.oIN_CH, bus.oTAP},
                    {4'(e.oc), 5'(e.pj), 4'(e.pi), 2'(e.q), 4'(e.ic), 4'(e.t)});
                chk($sformatf("acc@%0d", i),
                    {bus.oACC_CLR, bus.oACC_LAST}, {e.clr, e.last});
                chk($sformatf("wt_addr@%0d", i), bus.oWT_ADDR,
                    (e.oc * IN_CH + e.ic) * 9 + e.t);
            end
            ec = 0; ep = 0; ew = 0;
            if (i >= PIPE_LAT) begin
                p  = tr[i - PIPE_LAT];
                ec = p.tv && p.last;
                ep = ec && (p.q == 3);
                ew = p.oc * P + p.pj * PW + p.pi;
            end
            chk($sformatf("conv_pool@%0d", i),
                {bus.oCONV_VALID, bus.oPOOL_VALID}, {ec, ep});
            if (ep) chk($sformatf("wr_addr@%0d", i), bus.oWR_ADDR, ew);
            bus.iSTART = e.sin;
            bus.iHOLD  = e.hin;
        end
        if (stop_at < 0) begin
            @(negedge iCLK);
            chk_idle("idle_post");
            chk("done_count", dones, 1);
            bus.iHOLD = 1'b0;
        end
    endtask

    initial begin
        int ai;
        bus.iSTART = 1'b0;
        bus.iHOLD  = 1'b0;
        iRST = 1'b1;
        repeat (2) @(negedge iCLK);
        chk_idle("reset_strobes");
        chk("reset_idx", {bus.oOC, bus.oPOS_J, bus.oPOS_I, bus.oQUAD,
                          bus.oIN_CH, bus.oTAP, bus.oACC_CLR, bus.oACC_LAST}, 0);
        chk("reset_addr", {bus.oWT_ADDR, bus.oWR_ADDR}, 0);
        iRST = 1'b0;

        build(1'b1);
        run_layer(-1);

        // Abort right after a quad-3 last tap, with its pool still in flight.
        build(1'b1);
        ai = 0;
        for (int i = 300; i < tr.size() && ai == 0; i++)
            if (tr[i-1].tv && tr[i-1].last && tr[i-1].q == 3) ai = i;
        run_layer(ai);
        #2 iRST = 1'b1;
        bus.iSTART = 1'b0;
        bus.iHOLD  = 1'b0;
        #1 chk("async_rst", {bus.oBUSY, bus.oTAP_VALID, bus.oPOOL_VALID}, 0);
        repeat (2) @(negedge iCLK);
        iRST = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge iCLK);
            chk_idle($sformatf("post_rst_idle%0d", k));
        end

        build(1'b0);
        run_layer(-1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
